// File: rtl/jtag_reg_pkg.sv
// Shared definitions for the JTAG user register bank.
//   - ER1 frame geometry (total width and field offsets)
//   - sel state enum recording which user chain was last captured
package jtag_reg_pkg;

  // ER1 frame layout, LSB first: {data, addr, we}
  localparam int WE_BIT   = 0;
  localparam int ADDR_LSB = 1;

  // Bit position where the data field starts in an ER1 frame
  function automatic int data_lsb(input int addr_w);
    return 1 + addr_w;
  endfunction

  // Total ER1 frame width for a given address/data geometry
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Chain most recently captured; an update applies only to this chain
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ER1  = 2'd1,
    SEL_ER2  = 2'd2
  } sel_e;

endpackage

// File: rtl/jtag_shift_chain.sv
// Generic capture/shift data register for one JTAG user chain.
// Ports:
//   clk, rst_n   JTAG clock, asynchronous active-low reset
//   ce           chain selected (capture when !shift, shift when shift)
//   shift        Shift-DR state
//   tdi          serial data in, enters at the MSB
//   cap_val      parallel value loaded on capture
//   sr           current shift register contents
//   tdo          serial data out, always sr[0]
module jtag_shift_chain #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         shift,
  input  logic         tdi,
  input  logic [W-1:0] cap_val,
  output logic [W-1:0] sr,
  output logic         tdo
);

  logic [W-1:0] sr_d;
  logic [W-1:0] sr_q;

  // Next-state: parallel capture or right shift with tdi entering at the top
  always_comb begin
    sr_d = sr_q;
    if (ce) begin
      if (shift) begin
        sr_d = {tdi, sr_q[W-1:1]};
      end else begin
        sr_d = cap_val;
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= {W{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr  = sr_q;
  assign tdo = sr_q[0];

endmodule

// File: rtl/jtag_user_reg_bank.sv
// JTAG user register bank behind the ECP5 JTAGG primitive, clocked by JTCK.
// ER1 writes and reads NUM_REGS registers. ER2 reports and clears a
// saturating write counter and a sticky bad-address flag.
// Ports:
//   JTCK, JRSTN         JTAG clock, asynchronous active-low reset
//   JTDI, JSHIFT        serial data in, Shift-DR state
//   JUPDATE             Update-DR state
//   JCE1, JCE2          ER1 / ER2 capture-shift enables
//   JRTI1, JRTI2        Run-Test-Idle with ER1 / ER2 (JRTI2 not decoded)
//   JTDO1, JTDO2        serial outputs of ER1 / ER2
//   regs_o              register k at [k*DATA_W +: DATA_W]
//   wr_strobe_o         one-cycle pulse per register write
//   wr_addr_o           address of the last write
//   rti_pulse_o         one-cycle pulse after JRTI1 rises
module jtag_user_reg_bank
  import jtag_reg_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 2,
  parameter int                NUM_REGS  = 4,
  parameter int                COUNT_W   = 15,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                         JTCK,
  input  logic                         JRSTN,
  input  logic                         JTDI,
  input  logic                         JSHIFT,
  input  logic                         JUPDATE,
  input  logic                         JCE1,
  input  logic                         JCE2,
  input  logic                         JRTI1,
  input  logic                         JRTI2,
  output logic                         JTDO1,
  output logic                         JTDO2,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_strobe_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         rti_pulse_o
);

  localparam int FW       = frame_w(ADDR_W, DATA_W);
  localparam int DATA_LSB = data_lsb(ADDR_W);
  localparam int C2W      = COUNT_W + 1;
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  sel_e                sel_d, sel_q;
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [ADDR_W-1:0]   rd_addr_d, rd_addr_q;
  logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
  logic                err_d, err_q;
  logic [COUNT_W-1:0]  wr_cnt_d, wr_cnt_q;
  logic                wr_strobe_d, wr_strobe_q;
  logic                rti_pulse_d, rti_pulse_q;
  logic                jrti1_q;

  logic                ce2_s;
  logic [FW-1:0]       sr1_s;
  logic [C2W-1:0]      sr2_s;
  logic [FW-1:0]       cap1_s;
  logic [C2W-1:0]      cap2_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                upd_we_s;
  logic [ADDR_W-1:0]   upd_addr_s;
  logic [DATA_W-1:0]   upd_data_s;
  logic                addr_ok_s;
  logic                unused_s;

  // ER1 has priority if both enables are (illegally) high: ER2 then holds
  assign ce2_s = JCE2 & ~JCE1;

  assign cap1_s = {rd_data_s, rd_addr_q, err_q};
  assign cap2_s = {wr_cnt_q, err_q};

  jtag_shift_chain #(.W(FW)) u_er1 (
    .clk     (JTCK),
    .rst_n   (JRSTN),
    .ce      (JCE1),
    .shift   (JSHIFT),
    .tdi     (JTDI),
    .cap_val (cap1_s),
    .sr      (sr1_s),
    .tdo     (JTDO1)
  );

  jtag_shift_chain #(.W(C2W)) u_er2 (
    .clk     (JTCK),
    .rst_n   (JRSTN),
    .ce      (ce2_s),
    .shift   (JSHIFT),
    .tdi     (JTDI),
    .cap_val (cap2_s),
    .sr      (sr2_s),
    .tdo     (JTDO2)
  );

  assign upd_we_s   = sr1_s[WE_BIT];
  assign upd_addr_s = sr1_s[ADDR_LSB +: ADDR_W];
  assign upd_data_s = sr1_s[DATA_LSB +: DATA_W];
  assign addr_ok_s  = ({1'b0, upd_addr_s} < NUM_REGS_L);

  // Only ER2 bit0 is acted on; JRTI2 is reserved
  assign unused_s = ^{JRTI2, sr2_s[C2W-1:1]};

  // Read mux over implemented registers; rd_addr never points past them
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr_q == ADDR_W'(k)) begin
        rd_data_s = regs_q[k];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // Chain selection, update decode, register file, counter and error flag
  always_comb begin
    sel_d       = sel_q;
    regs_d      = regs_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    wr_cnt_d    = wr_cnt_q;
    wr_strobe_d = 1'b0;
    rti_pulse_d = JRTI1 & ~jrti1_q;

    if (JCE1 && !JSHIFT) begin
      sel_d = SEL_ER1;
    end else if (JCE2 && !JSHIFT) begin
      sel_d = SEL_ER2;
    end else begin
      sel_d = sel_q;
    end

    if (JUPDATE) begin
      case (sel_q)
        SEL_ER1: begin
          if (addr_ok_s) begin
            rd_addr_d = upd_addr_s;
            if (upd_we_s) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (upd_addr_s == ADDR_W'(k)) begin
                  regs_d[k] = upd_data_s;
                end else begin
                  regs_d[k] = regs_q[k];
                end
              end
              wr_addr_d   = upd_addr_s;
              wr_strobe_d = 1'b1;
              // Counter saturates at all-ones
              if (wr_cnt_q != {COUNT_W{1'b1}}) begin
                wr_cnt_d = wr_cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
              end else begin
                wr_cnt_d = wr_cnt_q;
              end
            end else begin
              wr_cnt_d = wr_cnt_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        SEL_ER2: begin
          if (sr2_s[0]) begin
            err_d    = 1'b0;
            wr_cnt_d = {COUNT_W{1'b0}};
          end else begin
            err_d    = err_q;
          end
        end
        default: begin
          err_d = err_q;
        end
      endcase
    end else begin
      err_d = err_q;
    end
  end

  // State registers
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      sel_q       <= SEL_NONE;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
      rd_addr_q   <= {ADDR_W{1'b0}};
      wr_addr_q   <= {ADDR_W{1'b0}};
      err_q       <= 1'b0;
      wr_cnt_q    <= {COUNT_W{1'b0}};
      wr_strobe_q <= 1'b0;
      rti_pulse_q <= 1'b0;
      jrti1_q     <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      regs_q      <= regs_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_strobe_q <= wr_strobe_d;
      rti_pulse_q <= rti_pulse_d;
      jrti1_q     <= JRTI1;
    end
  end

  // Flatten the register file onto the output bus
  always_comb begin
    regs_o = {(NUM_REGS*DATA_W){1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign rti_pulse_o = rti_pulse_q;

endmodule

// File: tb/tb_jtag_user_reg_bank.sv
// Self-checking bench for jtag_user_reg_bank: directed scenarios followed by
// random ER1/ER2 scans, compared against a register-level reference model.
module tb_jtag_user_reg_bank;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 3;
  localparam int CW = 3;
  localparam int FW = 1 + AW + DW;
  localparam int W2 = CW + 1;
  localparam logic [DW-1:0] RV = 8'hA5;

  logic JTCK = 1'b0;
  logic JRSTN = 1'b0;
  logic JTDI = 1'b0, JSHIFT = 1'b0, JUPDATE = 1'b0;
  logic JCE1 = 1'b0, JCE2 = 1'b0, JRTI1 = 1'b0, JRTI2 = 1'b0;
  logic JTDO1, JTDO2;
  logic [NR*DW-1:0] regs_o;
  logic wr_strobe_o;
  logic [AW-1:0] wr_addr_o;
  logic rti_pulse_o;

  jtag_user_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .COUNT_W(CW), .RESET_VAL(RV)
  ) dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .JCE1(JCE1), .JCE2(JCE2), .JRTI1(JRTI1),
    .JRTI2(JRTI2), .JTDO1(JTDO1), .JTDO2(JTDO2), .regs_o(regs_o),
    .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o),
    .rti_pulse_o(rti_pulse_o)
  );

  always #5 JTCK = ~JTCK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic [AW-1:0] m_rd;
  logic [AW-1:0] m_wa;
  logic          m_err;
  int            m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = RV;
    m_rd = '0; m_wa = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [NR*DW-1:0] model_regs();
    return {m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Full ER1 scan: capture, FW shifts, update; checks read-out and effects
  task automatic er1_scan(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    logic [FW-1:0] fin, fout, fexp;
    logic strobe_exp;
    fin  = {data, addr, we};
    fexp = {m_regs[m_rd], m_rd, m_err};
    @(negedge JTCK); JCE1 = 1'b1; JSHIFT = 1'b0;
    @(negedge JTCK); JSHIFT = 1'b1;
    for (int i = 0; i < FW; i++) begin
      fout[i] = JTDO1;
      JTDI = fin[i];
      @(negedge JTCK);
    end
    JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
    check("er1_readout", 32'(fout), 32'(fexp));
    strobe_exp = 1'b0;
    if (32'(addr) < NR) begin
      if (we) begin
        m_regs[addr] = data;
        m_wa = addr;
        strobe_exp = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      m_rd = addr;
    end else begin
      m_err = 1'b1;
    end
    @(negedge JTCK); JUPDATE = 1'b0;
    check("regs_after_upd", 32'(regs_o), 32'(model_regs()));
    check("strobe_after_upd", 32'(wr_strobe_o), 32'(strobe_exp));
    check("wr_addr", 32'(wr_addr_o), 32'(m_wa));
    @(negedge JTCK);
    check("strobe_one_cycle", 32'(wr_strobe_o), 32'd0);
  endtask

  // Full ER2 scan returning the captured frame; bit0 of shifted data = clear
  task automatic er2_scan(input logic clr, output logic [W2-1:0] got);
    logic [W2-1:0] fin, fexp;
    fin  = {W2'($urandom) >> 1} << 1;
    fin[0] = clr;
    fexp = {m_cnt[CW-1:0], m_err};
    @(negedge JTCK); JCE2 = 1'b1; JSHIFT = 1'b0;
    @(negedge JTCK); JSHIFT = 1'b1;
    for (int i = 0; i < W2; i++) begin
      got[i] = JTDO2;
      JTDI = fin[i];
      @(negedge JTCK);
    end
    JCE2 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
    check("er2_readout", 32'(got), 32'(fexp));
    if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    @(negedge JTCK); JUPDATE = 1'b0;
    check("er2_no_strobe", 32'(wr_strobe_o), 32'd0);
    check("er2_regs_hold", 32'(regs_o), 32'(model_regs()));
  endtask

  logic [W2-1:0] r2;

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(negedge JTCK);
    check("rst_regs", 32'(regs_o), 32'h00A5A5A5);
    check("rst_strobe", 32'(wr_strobe_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_rti", 32'(rti_pulse_o), 32'd0);
    check("rst_tdo1", 32'(JTDO1), 32'd0);
    JRSTN = 1'b1;
    er2_scan(1'b0, r2);
    check("rst_er2", 32'(r2), 32'd0);

    // Write 3C to reg 2, then read it back
    er1_scan(1'b1, 2'd2, 8'h3C);
    check("w2_byte", 32'(regs_o[23:16]), 32'h3C);
    er1_scan(1'b0, 2'd1, 8'hFF);   // readout shows {3C,2,0}; select reg 1
    er1_scan(1'b0, 2'd0, 8'h00);   // readout shows reg 1 = A5

    // Invalid address sets sticky err, visible on ER1 and ER2, cleared by ER2
    er1_scan(1'b1, 2'd3, 8'h77);
    check("bad_no_write", 32'(regs_o), 32'h003CA5A5);
    er1_scan(1'b0, 2'd0, 8'h00);
    er2_scan(1'b1, r2);
    check("err_on_er2", 32'(r2[0]), 32'd1);
    er2_scan(1'b0, r2);
    check("err_cleared", 32'(r2), 32'd0);

    // Counter saturation at 7 after nine writes
    for (int i = 0; i < 9; i++) er1_scan(1'b1, 2'(i % NR), 8'(i * 17 + 3));
    er2_scan(1'b0, r2);
    check("cnt_sat", 32'(r2[W2-1:1]), 32'd7);

    // rti pulse: one cycle after JRTI1 rises
    @(negedge JTCK); JRTI1 = 1'b1;
    @(negedge JTCK);
    check("rti_high", 32'(rti_pulse_o), 32'd1);
    @(negedge JTCK);
    check("rti_once", 32'(rti_pulse_o), 32'd0);
    JRTI1 = 1'b0;

    // Reset in the middle of an ER1 shift discards the partial frame
    @(negedge JTCK); JCE1 = 1'b1; JSHIFT = 1'b0;
    @(negedge JTCK); JSHIFT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      JTDI = 1'b1;
      @(negedge JTCK);
    end
    JRSTN = 1'b0;
    #1;
    model_reset();
    check("mid_rst_regs", 32'(regs_o), 32'(model_regs()));
    check("mid_rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("mid_rst_tdo1", 32'(JTDO1), 32'd0);
    JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    @(negedge JTCK); JRSTN = 1'b1;
    @(negedge JTCK); JUPDATE = 1'b1;
    @(negedge JTCK); JUPDATE = 1'b0;
    check("upd_sel_none_regs", 32'(regs_o), 32'(model_regs()));
    check("upd_sel_none_strobe", 32'(wr_strobe_o), 32'd0);
    er2_scan(1'b0, r2);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      er1_scan(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 5) == 0) er2_scan(1'($urandom_range(0, 1)), r2);
    end
    er1_scan(1'b0, 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
